// File: rtl/feature_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : feature_bank_router
// Purpose  : Routes fetcher line writes into a ring of scratchpad feature
//            banks. Each bank is filled with a latched number of lines, then
//            marked full and handed to the consumer, which releases banks in
//            ring order.
// Options  : FEATURE_BANK_ROUTER_ERR_EN - compiles in sticky protocol error
//            detection (write while not ready, release while not valid).
// Revision : 1.0 - initial release
// ============================================================================
module feature_bank_router #(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic [ADDR_WIDTH:0]          i_fill_len,
  output logic                         o_wr_ready,
  input  logic                         i_rd_release,
  output logic [NUM_BANKS-1:0]         o_bank_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_bank_wr_addr,
  output logic [DATA_WIDTH-1:0]        o_bank_wr_data,
  output logic                         o_rd_valid,
  output logic [$clog2(NUM_BANKS)-1:0] o_rd_bank,
  output logic [NUM_BANKS-1:0]         o_bank_full,
  output logic                         o_fill_done,
  output logic                         o_err
);

  localparam int PW = $clog2(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]       c_LAST_BANK = PW'(NUM_BANKS - 1);

  logic [PW-1:0]           r_wp;
  logic [PW-1:0]           r_rp;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [ADDR_WIDTH:0]     r_len;
  logic [NUM_BANKS-1:0]    r_bank_full;
  logic [NUM_BANKS-1:0]    r_bank_wr_en;
  logic [ADDR_WIDTH-1:0]   r_bank_wr_addr;
  logic [DATA_WIDTH-1:0]   r_bank_wr_data;
  logic                    r_fill_done;

  logic                    w_wr_ready;
  logic                    w_accept;
  logic                    w_release;
  logic                    w_last;
  logic [ADDR_WIDTH:0]     w_len_sat;
  logic [ADDR_WIDTH:0]     w_len_eff;
  logic [ADDR_WIDTH:0]     w_cnt_inc;
  logic [PW-1:0]           w_wp_next;
  logic [PW-1:0]           w_rp_next;
  logic [NUM_BANKS-1:0]    w_wp_onehot;
  logic [NUM_BANKS-1:0]    w_full_next;

  // Handshake and ring decode, all from registered state
  assign w_wr_ready  = ~r_bank_full[r_wp];
  assign w_accept    = i_wr_en & w_wr_ready;
  assign w_release   = i_rd_release & r_bank_full[r_rp];
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_wp_next   = (r_wp == c_LAST_BANK) ? '0 : r_wp + 1'b1;
  assign w_rp_next   = (r_rp == c_LAST_BANK) ? '0 : r_rp + 1'b1;
  assign w_wp_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << r_wp;

  // Clamp requested fill length into 1..2^ADDR_WIDTH
  always_comb begin
    w_len_sat = i_fill_len;
    if (i_fill_len == '0) begin
      w_len_sat = {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else if (i_fill_len > c_MAX_LEN) begin
      w_len_sat = c_MAX_LEN;
    end
  end

  // The first line of a fill uses the live length; later lines use the latch
  assign w_len_eff = (r_cnt == '0) ? w_len_sat : r_len;
  assign w_last    = w_accept & (w_cnt_inc == w_len_eff);

  // Full flags: completion sets the write bank, release clears the read bank
  always_comb begin
    w_full_next = r_bank_full;
    if (w_last) begin
      w_full_next[r_wp] = 1'b1;
    end
    if (w_release) begin
      w_full_next[r_rp] = 1'b0;
    end
  end

  // Ring pointers, fill counter, length latch and registered write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_cnt          <= '0;
      r_len          <= '0;
      r_bank_full    <= '0;
      r_bank_wr_en   <= '0;
      r_bank_wr_addr <= '0;
      r_bank_wr_data <= '0;
      r_fill_done    <= 1'b0;
    end else begin
      r_bank_wr_en <= w_accept ? w_wp_onehot : '0;
      r_fill_done  <= w_last;
      r_bank_full  <= w_full_next;
      if (w_accept) begin
        r_bank_wr_addr <= r_cnt[ADDR_WIDTH-1:0];
        r_bank_wr_data <= i_wr_data;
        if (r_cnt == '0) begin
          r_len <= w_len_sat;
        end
        if (w_last) begin
          r_cnt <= '0;
          r_wp  <= w_wp_next;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
      if (w_release) begin
        r_rp <= w_rp_next;
      end
    end
  end

`ifdef FEATURE_BANK_ROUTER_ERR_EN
  logic r_err;

  // Sticky flag for writes into a full bank or releases of an empty one
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((i_wr_en & ~w_wr_ready) | (i_rd_release & ~r_bank_full[r_rp])) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_wr_ready     = w_wr_ready;
  assign o_bank_wr_en   = r_bank_wr_en;
  assign o_bank_wr_addr = r_bank_wr_addr;
  assign o_bank_wr_data = r_bank_wr_data;
  assign o_rd_valid     = r_bank_full[r_rp];
  assign o_rd_bank      = r_rp;
  assign o_bank_full    = r_bank_full;
  assign o_fill_done    = r_fill_done;

endmodule
`default_nettype wire

// File: tb/tb_feature_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_bank_router
// Purpose  : Drives a 2-bank and a 4-bank router with the same directed
//            stimulus, compares both against a ring-of-banks model every
//            cycle, and pins key points with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_bank_router;

  localparam int DW = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_release = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   fill_len = '0;

  logic          w2_ready, w2_rv, w2_done, w2_err;
  logic [1:0]    w2_wen, w2_full;
  logic [0:0]    w2_rb;
  logic [AW-1:0] w2_addr;
  logic [DW-1:0] w2_data;

  logic          w4_ready, w4_rv, w4_done, w4_err;
  logic [3:0]    w4_wen, w4_full;
  logic [1:0]    w4_rb;
  logic [AW-1:0] w4_addr;
  logic [DW-1:0] w4_data;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  feature_bank_router #(.NUM_BANKS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut2 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_fill_len(fill_len), .o_wr_ready(w2_ready), .i_rd_release(rd_release),
    .o_bank_wr_en(w2_wen), .o_bank_wr_addr(w2_addr), .o_bank_wr_data(w2_data),
    .o_rd_valid(w2_rv), .o_rd_bank(w2_rb), .o_bank_full(w2_full),
    .o_fill_done(w2_done), .o_err(w2_err)
  );

  feature_bank_router #(.NUM_BANKS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut4 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_fill_len(fill_len), .o_wr_ready(w4_ready), .i_rd_release(rd_release),
    .o_bank_wr_en(w4_wen), .o_bank_wr_addr(w4_addr), .o_bank_wr_data(w4_data),
    .o_rd_valid(w4_rv), .o_rd_bank(w4_rb), .o_bank_full(w4_full),
    .o_fill_done(w4_done), .o_err(w4_err)
  );

  // ---------------- model: ring of banks with fill counters ----------------
  int            nb[2] = '{2, 4};
  int            mwp[2], mrp[2], mcnt[2], mlen[2];
  bit [7:0]      mfull[2];
  bit [7:0]      ewen[2];
  logic [AW-1:0] eaddr[2];
  logic [DW-1:0] edata[2];
  bit            edone[2], eerr[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rdy, acc, rel;
      int len;
      if (!rst) begin
        mwp[k] = 0; mrp[k] = 0; mcnt[k] = 0; mlen[k] = 0; mfull[k] = '0;
        ewen[k] = '0; eaddr[k] = '0; edata[k] = '0; edone[k] = 0; eerr[k] = 0;
      end else begin
        rdy = !mfull[k][mwp[k]];
        acc = wr_en && rdy;
        rel = rd_release && mfull[k][mrp[k]];
`ifdef FEATURE_BANK_ROUTER_ERR_EN
        if ((wr_en && !rdy) || (rd_release && !mfull[k][mrp[k]])) eerr[k] = 1;
`endif
        ewen[k] = '0;
        edone[k] = 0;
        if (acc) begin
          ewen[k]  = 8'(1) << mwp[k];
          eaddr[k] = AW'(mcnt[k]);
          edata[k] = wr_data;
          if (mcnt[k] == 0) begin
            len = int'(fill_len);
            if (len == 0) len = 1;
            if (len > (1 << AW)) len = 1 << AW;
            mlen[k] = len;
          end
          mcnt[k] = mcnt[k] + 1;
          if (mcnt[k] == mlen[k]) begin
            mcnt[k] = 0;
            edone[k] = 1;
            mfull[k][mwp[k]] = 1;
            mwp[k] = (mwp[k] + 1) % nb[k];
          end
        end
        if (rel) begin
          mfull[k][mrp[k]] = 0;
          mrp[k] = (mrp[k] + 1) % nb[k];
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic [7:0] wen,
                     input logic [AW-1:0] addr, input logic [DW-1:0] data,
                     input logic rv, input int rb, input logic [7:0] full,
                     input logic done, input logic err);
    string p;
    p = $sformatf("nb%0d", nb[k]);
    check({p, " wr_ready"}, DW'(rdy), DW'(!mfull[k][mwp[k]]));
    check({p, " bank_wr_en"}, DW'(wen), DW'(ewen[k]));
    check({p, " bank_wr_addr"}, DW'(addr), DW'(eaddr[k]));
    check({p, " bank_wr_data"}, data, edata[k]);
    check({p, " rd_valid"}, DW'(rv), DW'(mfull[k][mrp[k]]));
    check({p, " rd_bank"}, DW'(rb), DW'(mrp[k]));
    check({p, " bank_full"}, DW'(full), DW'(mfull[k]));
    check({p, " fill_done"}, DW'(done), DW'(edone[k]));
    check({p, " err"}, DW'(err), DW'(eerr[k]));
  endtask

  // Per-cycle compare of both routers against the model
  always @(negedge clk) begin
    if (checking) begin
      cmp(0, w2_ready, 8'(w2_wen), w2_addr, w2_data, w2_rv, int'(w2_rb), 8'(w2_full), w2_done, w2_err);
      cmp(1, w4_ready, 8'(w4_wen), w4_addr, w4_data, w4_rv, int'(w4_rb), 8'(w4_full), w4_done, w4_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic we, input logic [DW-1:0] d, input logic rel);
    #1;
    rst = 1'b1; wr_en = we; wr_data = d; rd_release = rel;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_release = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {4{32'hA500_0000 + 32'(i)}};
  endfunction

  logic exp_err;

  initial begin
`ifdef FEATURE_BANK_ROUTER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset state
    do_reset();
    checking = 1;
    check("reset bank_full", DW'(w2_full), 0);
    check("reset wr_ready", DW'(w2_ready), 1);
    check("reset bank_wr_en", DW'(w2_wen), 0);

    // Four-line fill of bank 0
    fill_len = 9'd4;
    for (int i = 0; i < 4; i++) begin
      step(1, pat(i), 0);
      check("fill4 wen", DW'(w2_wen), 2'b01);
      check("fill4 addr", DW'(w2_addr), DW'(i));
      check("fill4 data", w2_data, pat(i));
      check("fill4 done", DW'(w2_done), DW'(i == 3));
    end
    check("fill4 full", DW'(w2_full), 2'b01);
    check("fill4 rd_valid", DW'(w2_rv), 1);
    check("fill4 rd_bank", DW'(w2_rb), 0);
    step(0, '0, 0);
    check("fill4 done pulse ends", DW'(w2_done), 0);

    // Two-line fills until both banks are full, then a dropped write
    do_reset();
    fill_len = 9'd2;
    for (int i = 0; i < 4; i++) step(1, pat(10 + i), 0);
    check("both full", DW'(w2_full), 2'b11);
    check("both full ready", DW'(w2_ready), 0);
    step(1, pat(99), 0);
    check("dropped wen", DW'(w2_wen), 0);
    step(0, '0, 0);
    check("drop err", DW'(w2_err), DW'(exp_err));
    step(0, '0, 1);
    check("release0 full", DW'(w2_full), 2'b10);
    check("release0 rp", DW'(w2_rb), 1);
    step(0, '0, 1);
    check("release1 rp wrap", DW'(w2_rb), 0);
    check("release1 full", DW'(w2_full), 2'b00);

    // Reset in the middle of a fill
    do_reset();
    fill_len = 9'd4;
    step(1, pat(20), 0);
    step(1, pat(21), 0);
    do_reset();
    check("midrst wen", DW'(w2_wen), 0);
    check("midrst addr", DW'(w2_addr), 0);
    check("midrst data", w2_data, 0);
    check("midrst done", DW'(w2_done), 0);
    check("midrst ready", DW'(w2_ready), 1);
    step(1, pat(22), 0);
    check("restart wen", DW'(w2_wen), 2'b01);
    check("restart addr", DW'(w2_addr), 0);

    // Length change mid-fill, then release coinciding with completion
    do_reset();
    fill_len = 9'd4;
    step(1, pat(30), 0);
    fill_len = 9'd8;
    for (int i = 1; i < 4; i++) step(1, pat(30 + i), 0);
    check("latch4 done", DW'(w2_done), 1);
    check("latch4 full", DW'(w2_full), 2'b01);
    step(1, pat(40), 0);
    fill_len = 9'd3;
    for (int i = 1; i < 7; i++) step(1, pat(40 + i), 0);
    check("latch8 not done", DW'(w2_done), 0);
    step(1, pat(47), 1);
    check("latch8 done", DW'(w2_done), 1);
    check("latch8 addr", DW'(w2_addr), 7);
    check("coinc full", DW'(w2_full), 2'b10);
    check("coinc rp", DW'(w2_rb), 1);
    check("coinc ready", DW'(w2_ready), 1);

    // Zero length: single-line fills around the 4-bank ring
    do_reset();
    fill_len = 9'd0;
    for (int i = 0; i < 4; i++) begin
      step(1, pat(50 + i), 0);
      check("len0 done", DW'(w4_done), 1);
      check("len0 wen", DW'(w4_wen), DW'(4'b0001 << i));
    end
    check("len0 full", DW'(w4_full), 4'hF);
    check("len0 ready", DW'(w4_ready), 0);
    step(0, '0, 1);
    check("len0 rel rp", DW'(w4_rb), 1);
    check("len0 wp wrap ready", DW'(w4_ready), 1);
    step(1, pat(60), 0);
    check("len0 wrap wen", DW'(w4_wen), 4'b0001);

    // Oversized length saturates to 2^ADDR_WIDTH lines
    do_reset();
    fill_len = 9'd300;
    for (int i = 0; i < 255; i++) step(1, pat(100 + i), 0);
    check("sat not full", DW'(w2_full), 0);
    step(1, pat(355), 0);
    check("sat done", DW'(w2_done), 1);
    check("sat addr", DW'(w2_addr), 255);
    check("sat full", DW'(w2_full), 2'b01);
    step(0, '0, 0);

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
